// File: rtl/sinegen_ctrl.sv
// sinegen_ctrl: phase-accumulator sequencer driving both address ports of a dual-port sine ROM.
// Optional build macro SINEGEN_BURST_EN adds a burst_cycles input that ends generation after N wraps.
module sinegen_ctrl #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int INCR_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  // cfg: a word transfers on any rising edge where cfg_valid && cfg_ready; the offerer must hold
  // cfg_valid and the data stable until that edge, and cfg_ready never depends on cfg_valid.
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [INCR_WIDTH-1:0]    cfg_incr,
  input  logic [ADDRESS_WIDTH-1:0] cfg_offset,
`ifdef SINEGEN_BURST_EN
  input  logic [7:0]               burst_cycles,
`endif
  output logic [ADDRESS_WIDTH-1:0] addr1,
  output logic [ADDRESS_WIDTH-1:0] addr2,
  output logic                     sample_valid,
  output logic                     wrap,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_acc;
  logic [INCR_WIDTH-1:0]    r_incr;
  logic [ADDRESS_WIDTH-1:0] r_offset;
  logic [INCR_WIDTH-1:0]    r_hold_incr;
  logic [ADDRESS_WIDTH-1:0] r_hold_offset;
  logic                     r_pending;
  logic [ADDRESS_WIDTH-1:0] r_addr2;
  logic                     r_wrap;
  logic                     r_busy;
  logic                     r_sample_valid;

  logic [ADDRESS_WIDTH:0]   w_sum;
  logic                     w_wrap;
  logic                     w_incr_zero;
  logic                     w_accept;
  logic                     w_apply;
  logic                     w_burst_done;
  logic                     w_start_taken;
  state_t                   w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] w_acc_nxt;
  logic [INCR_WIDTH-1:0]    w_incr_nxt;
  logic [ADDRESS_WIDTH-1:0] w_offset_nxt;

  assign w_sum       = {1'b0, r_acc} + {{(ADDRESS_WIDTH + 1 - INCR_WIDTH){1'b0}}, r_incr};
  assign w_wrap      = (r_state != S_IDLE) && w_sum[ADDRESS_WIDTH];
  assign w_incr_zero = (r_incr == '0);
  assign w_accept    = cfg_valid && !r_pending;
  // A zero step never wraps, so a held word would otherwise wait forever.
  assign w_apply     = r_pending && (w_wrap || w_incr_zero || (r_state == S_IDLE));

`ifdef SINEGEN_BURST_EN
  logic [7:0] r_burst_len;
  logic [7:0] r_wrap_cnt;
  assign w_burst_done = w_wrap && (r_burst_len != 8'd0) && ((r_wrap_cnt + 8'd1) == r_burst_len);
`else
  assign w_burst_done = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_start_taken = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_acc_nxt = '0;
        if (start && !stop) begin
          w_state_nxt   = S_RUN;
          w_start_taken = 1'b1;
        end
      end
      S_RUN: begin
        w_acc_nxt = w_sum[ADDRESS_WIDTH-1:0];
        if (w_burst_done || (stop && w_incr_zero)) begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
        end else if (stop) begin
          w_state_nxt = S_STOPPING;
        end
      end
      S_STOPPING: begin
        w_acc_nxt = w_sum[ADDRESS_WIDTH-1:0];
        if (w_burst_done) begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
        end else if (start) begin
          w_state_nxt   = S_RUN;
          w_start_taken = 1'b1;
        end else if (w_wrap || w_incr_zero) begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_acc_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_incr_nxt   = r_incr;
    w_offset_nxt = r_offset;
    if (w_apply) begin
      w_incr_nxt   = r_hold_incr;
      w_offset_nxt = r_hold_offset;
    end else if (w_accept && (r_state == S_IDLE)) begin
      w_incr_nxt   = cfg_incr;
      w_offset_nxt = cfg_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_incr         <= INCR_WIDTH'(1);
      r_offset       <= '0;
      r_hold_incr    <= '0;
      r_hold_offset  <= '0;
      r_pending      <= 1'b0;
      r_addr2        <= '0;
      r_wrap         <= 1'b0;
      r_busy         <= 1'b0;
      r_sample_valid <= 1'b0;
`ifdef SINEGEN_BURST_EN
      r_burst_len    <= 8'd0;
      r_wrap_cnt     <= 8'd0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_acc          <= w_acc_nxt;
      r_incr         <= w_incr_nxt;
      r_offset       <= w_offset_nxt;
      r_addr2        <= w_acc_nxt + w_offset_nxt;
      r_wrap         <= w_wrap;
      r_busy         <= (w_state_nxt != S_IDLE);
      r_sample_valid <= r_busy;
      if (w_accept && (r_state != S_IDLE)) begin
        r_hold_incr   <= cfg_incr;
        r_hold_offset <= cfg_offset;
        r_pending     <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
`ifdef SINEGEN_BURST_EN
      if (w_start_taken) begin
        r_burst_len <= burst_cycles;
        r_wrap_cnt  <= 8'd0;
      end else if (w_wrap) begin
        r_wrap_cnt <= r_wrap_cnt + 8'd1;
      end
`endif
    end
  end

  assign addr1        = r_acc;
  assign addr2        = r_addr2;
  assign wrap         = r_wrap;
  assign busy         = r_busy;
  assign sample_valid = r_sample_valid;
  assign cfg_ready    = !r_pending;
  assign dbg_state    = r_state;

endmodule

// File: doc/sinegen_ctrl.md
# sinegen_ctrl

Sequencer for the dual-port synchronous sine ROM. Runs a phase accumulator and drives both ROM address ports: port 1 gets the phase and port 2 gets the phase plus a programmable offset. Accepts frequency and offset updates through a valid/ready handshake and applies them only at a phase wrap, so frequency changes are glitch-free. Produces a sample-valid strobe aligned to the ROM's 1-cycle read latency. Sits between the top-level control inputs and the ROM.

## Interface
- ADDRESS_WIDTH, 8, width of phase accumulator, offset and ROM addresses
- INCR_WIDTH, 8, width of phase increment (must be ≤ ADDRESS_WIDTH)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begin generation
- stop  in  1  pulse; finish current period, then idle
- cfg_valid  in  1  config word offered
- cfg_ready  out  1  config holding slot free
- cfg_incr  in  INCR_WIDTH  phase step per cycle
- cfg_offset  in  ADDRESS_WIDTH  port-2 phase offset
- addr1  out  ADDRESS_WIDTH  ROM port-1 address (registered)
- addr2  out  ADDRESS_WIDTH  ROM port-2 address (registered)
- sample_valid  out  1  ROM dout1/dout2 valid this cycle
- wrap  out  1  one-cycle pulse when the accumulator wraps
- busy  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE: accumulator `acc` = 0; addresses held.
  - RUN: `acc` advances by `incr` every cycle.
  - STOPPING: `acc` still advances; returns to IDLE at the next wrap.
- `acc` update: `acc <= acc + incr`, modulo 2^ADDRESS_WIDTH; `incr` is zero-extended.
- Wrap condition: carry out of that add.
- On the wrap edge, STOPPING and burst termination force `acc <= 0`.
- Outputs: `addr1 = acc`; `addr2 = (acc + offset) mod 2^ADDRESS_WIDTH`. Both are registered and update on the same edge as `acc`.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→STOPPING on `stop`.
  - STOPPING→IDLE on wrap.
  - STOPPING→RUN on `start` (cancels the stop).
  - `start` in RUN is ignored; `stop` in IDLE or STOPPING is ignored.
- `start` and `stop` together in IDLE: stop wins, stay IDLE. Together in RUN: go to STOPPING.
- `stop` in RUN while active `incr` = 0: go straight to IDLE next edge with `acc` = 0. Without this the block would wait forever for a wrap.
- Config handshake:
  - Transfer occurs when `cfg_valid && cfg_ready`.
  - `cfg_ready = !pending`.
  - In IDLE the config is applied to active `incr`/`offset` on the accepting edge; `pending` is not set.
  - In RUN or STOPPING the config is stored in a holding register and `pending` is set.
  - The held config is applied and `pending` cleared on the next wrap edge. If active `incr` = 0, it is applied on the next edge instead.
  - The new `offset` takes effect in `addr2` on the same edge as the new `incr`.
- Reset values:
  - state = IDLE; `acc` = 0; `incr` = 1; `offset` = 0; `pending` = 0.
  - `addr1` = 0; `addr2` = 0; `sample_valid` = 0; `wrap` = 0; `busy` = 0; `cfg_ready` = 1.
- Reset mid-run aborts immediately and discards any pending config.

## Timing
- `start` sampled at edge t:
  - `busy` = 1 and `addr1` = 0 from t+1.
  - `addr1` = `incr` at t+2.
  - `sample_valid` is high from t+2, one cycle after the ROM captures the address.
- `sample_valid` is `busy` delayed by one cycle, with this exception: it also stays high for the one cycle after the return to IDLE, covering the final sample.
- `wrap` is registered and high in the cycle after the wrapping edge.
- Pending config is applied at the wrapping edge. The first address computed with the new `incr` appears one cycle later.
- Back-to-back configs: the second is stalled (`cfg_ready` = 0) until the wrap edge. `cfg_ready` returns to 1 in the following cycle.

## Configuration
- Macro `SINEGEN_BURST_EN`:
  - Defined: adds input `burst_cycles [7:0]`, latched on `start`. The block counts wraps and enters IDLE (`acc` = 0) at the wrap that makes the count equal `burst_cycles`, exactly as a completed stop. `burst_cycles` = 0 means unlimited. An explicit `stop` still works.
  - Not defined: no port, no counter; runs until stopped.

## Test plan
- Reset, then check idle outputs: `addr1` = 0, `addr2` = 0, `busy` = 0, `cfg_ready` = 1, `sample_valid` = 0.
- IDLE config `incr` = 64, `offset` = 128, then `start`:
  - `addr1` sequence 0, 64, 128, 192, 0.
  - `addr2` sequence 128, 192, 0, 64, 128.
  - `wrap` pulses one cycle after the 192→0 edge.
  - `sample_valid` rises one cycle after `busy`.
- Running at `incr` = 64, `stop` issued while `addr1` = 64 → `addr1` continues 128, 192, then 0 with `busy` = 0. `sample_valid` is high one further cycle.
- Running at `incr` = 32, offer `cfg_incr` = 96 while `addr1` = 32:
  - `cfg_ready` drops.
  - The old step continues until wrap, then `addr1` goes 0, 96, 192, with the new step following the wrap.
  - A second `cfg_valid` during this window is held off until `cfg_ready` returns.
- `incr` = 0 running plus `stop` → IDLE next cycle. Simultaneous `start` and `stop` in IDLE → stays IDLE.
- With `SINEGEN_BURST_EN`: `burst_cycles` = 2, `incr` = 128 → `addr1` sequence 0, 128, 0, 128, then IDLE with `acc` = 0 and exactly 2 `wrap` pulses. Separately, reset asserted mid-burst → all outputs at reset values next cycle.
